dmem_responder: RTL and testbench
=================================

// Module: dmem_responder
// PURPOSE
//  Memory-side responder for the core's load/store port: accepts one request at a time,
//  applies RV32I width/sign rules and returns a registered response after configurable
//  wait states. Sits between the core's data-access path and a word-organised data RAM.
//  Lets the pipeline tolerate multi-cycle memory; flags misaligned/out-of-range accesses.
// PARAMETERS
//  ADDR_WIDTH   10  word-address bits of internal RAM (2**ADDR_WIDTH x 32-bit words)
//  WAIT_STATES   1  extra cycles between accept and RAM access (0..15)
// PORTS
//  clock      in   1   single clock, all state on rising edge
//  clear      in   1   reset, asynchronous, active-high
//  req_valid  in   1   request present
//  req_ready  out  1   responder can accept (high only in IDLE)
//  req_addr   in   32  byte address
//  req_we     in   1   1=store, 0=load
//  req_funct3 in   3   RV32I width/sign code (LB/LH/LW/LBU/LHU, SB/SH/SW)
//  req_wdata  in   32  store data, right-aligned (byte in [7:0], half in [15:0])
//  rsp_valid  out  1   response present
//  rsp_ready  in   1   requester takes response
//  rsp_rdata  out  32  load result, extended; 0 for stores and errors
//  rsp_err    out  1   misaligned, out-of-range or illegal funct3
// BEHAVIOUR
//  Reset: state=IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, wait counter=0;
//   RAM contents are not cleared.
//  Accept on edge with req_valid&req_ready: latch addr, we, funct3, wdata; compute err.
//  FSM: IDLE -accept-> WAIT (WAIT_STATES>0) or ACCESS (WAIT_STATES==0).
//   WAIT: counter loads WAIT_STATES-1, decrements each cycle; at 0 -> ACCESS.
//   ACCESS: one cycle; store commits byte-enabled write, load registers RAM word -> RESP.
//   RESP: rsp_valid=1, outputs stable; rsp_valid&rsp_ready -> IDLE.
//  Latency: rsp_valid first high WAIT_STATES+2 edges after the accepting edge.
//  No back-to-back accept: req_ready=0 from accept edge until the RESP->IDLE edge.
//  Error rules (err=1 => no RAM write, rsp_rdata=0, still walks WAIT/ACCESS/RESP):
//   halfword with addr[0]!=0; word with addr[1:0]!=0;
//   addr[31:ADDR_WIDTH+2]!=0; funct3 in {011,110,111}; store with funct3 in {100,101}.
//  Store byte lanes: SB -> lane addr[1:0] gets wdata[7:0]; SH -> lanes {addr[1],0..1}
//   get wdata[15:0]; SW -> all four. Unselected lanes untouched.
//  Load extract: LB/LBU byte addr[1:0], LH/LHU half addr[1], LW whole word;
//   LB/LH sign-extend, LBU/LHU zero-extend to 32 bits.
//  Read-after-write: a load accepted after a store's RESP returns the new data.
//  clear mid-operation: FSM to IDLE immediately, rsp_valid drops; a store not yet in
//   ACCESS is dropped; a write whose ACCESS edge coincides with clear is not committed.
//  rsp_ready while not in RESP is ignored; req fields ignored unless accepted.
// STRUCTURE
//  Shared package riscv_mem_pkg: funct3 constants (F3_B,F3_H,F3_W,F3_BU,F3_HU),
//   state encoding (S_IDLE,S_WAIT,S_ACCESS,S_RESP).
//  Sub-module byte_en_ram: 32-bit wide, 4-bit byte enable, registered read, 1 port,
//   depth 2**ADDR_WIDTH; instantiated once. Alignment/extension logic stays in top.
// TESTING (WAIT_STATES=1, ADDR_WIDTH=10 unless noted)
//  1 SW 0xDEADBEEF @0x10, then LW @0x10 -> rsp_rdata=0xDEADBEEF, err=0,
//    rsp_valid 3 edges after each accept.
//  2 SB 0x80 @0x21 over word 0 @0x20, LB @0x21 -> 0xFFFFFF80; LBU -> 0x00000080;
//    LW @0x20 -> 0x00008000.
//  3 SH 0xBEEF @0x32, LH @0x32 -> 0xFFFFBEEF, LHU -> 0x0000BEEF; LH @0x31 -> err=1,
//    rdata=0; SW @0x12 -> err=1 and word @0x10 unchanged.
//  4 LW @0x00001000 (beyond 4 KiB) -> err=1; funct3=011 -> err=1;
//    SW with funct3=100 -> err=1, no write.
//  5 Hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid/rdata stable, req_ready=0;
//    then rsp_ready=1 -> IDLE next edge, new request accepted same cycle as req_ready=1.
//  6 Assert clear during WAIT of SW 0x12345678 @0x40 -> rsp_valid=0, req_ready=1
//    immediately; later LW @0x40 returns prior value. Repeat with WAIT_STATES=0 and 3
//    checking latency 2 and 5.

Source files
------------

// File: rtl/riscv_mem_pkg.sv
// Shared load/store definitions: RV32I funct3 width codes, responder FSM
// encoding and the byte-enable helper used for stores.
package riscv_mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_ACCESS = 2'd2,
    S_RESP   = 2'd3
  } mem_state_t;

  // Byte lanes touched by a store of the given width at byte offset off.
  function automatic logic [3:0] byte_enable(input logic [2:0] f3, input logic [1:0] off);
    logic [3:0] be;
    case (f3)
      F3_B:    be = 4'b0001 << off;
      F3_H:    be = off[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/byte_en_ram.sv
// Single-port word RAM with per-byte write enables and a registered read.
// Contents are never reset.
module byte_en_ram #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clock,
  input  logic                  en,
  input  logic [3:0]            be,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata
);

  logic [31:0] mem [2**ADDR_WIDTH];

  // Enabled access: write the selected lanes and register the old word on the read port.
  always_ff @(posedge clock) begin
    if (en) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Memory-side responder for the core load/store port. One request in flight:
// accept in IDLE, optional wait states, one RAM access cycle, then a held
// response until the requester takes it.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high; valid, once raised, holds with its payload stable until that edge.
//
// Timing: the RAM read is registered in ACCESS, and the first RESP cycle loads
// the extended result into the output register, so rsp_valid rises
// WAIT_STATES+2 edges after the accepting edge.
module dmem_responder
  import riscv_mem_pkg::*;
#(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_STATES = 1
) (
  input  logic        clock,
  input  logic        clear,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [1:0]  state
);

  localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  mem_state_t state_q, state_d;
  logic [3:0] cnt_q;

  logic [ADDR_WIDTH-1:0] word_q;
  logic [1:0]            off_q;
  logic                  we_q;
  logic [2:0]            f3_q;
  logic [31:0]           wdata_q;
  logic                  err_q;

  logic        rsp_valid_q;
  logic        rsp_err_q;
  logic [31:0] rsp_rdata_q;

  logic        accept;
  logic        acc_err;
  logic        ram_en;
  logic [3:0]  ram_be;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;
  logic [31:0] shifted;
  logic [31:0] load_data;

  assign req_ready = (state_q == S_IDLE);
  assign accept    = req_valid && req_ready;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;
  assign state     = state_q;

  // Classify the incoming request: misalignment, range and illegal width codes.
  always_comb begin
    acc_err = 1'b0;
    case (req_funct3)
      F3_B, F3_BU: acc_err = 1'b0;
      F3_H, F3_HU: acc_err = req_addr[0];
      F3_W:        acc_err = |req_addr[1:0];
      default:     acc_err = 1'b1;
    endcase
    if (req_we && (req_funct3 == F3_BU || req_funct3 == F3_HU)) acc_err = 1'b1;
    if (|req_addr[31:ADDR_WIDTH+2]) acc_err = 1'b1;
  end

  // FSM state register.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (accept) state_d = (WAIT_STATES == 0) ? S_ACCESS : S_WAIT;
      S_WAIT:   if (cnt_q == 4'd0) state_d = S_ACCESS;
      S_ACCESS: state_d = S_RESP;
      S_RESP:   if (rsp_valid_q && rsp_ready) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Wait-state counter: loaded on accept, counts down while in WAIT.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      cnt_q <= 4'd0;
    end else if (accept) begin
      cnt_q <= WAIT_LOAD;
    end else if (state_q == S_WAIT && cnt_q != 4'd0) begin
      cnt_q <= cnt_q - 4'd1;
    end
  end

  // Capture the request fields and its error status on the accepting edge.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      word_q  <= '0;
      off_q   <= 2'd0;
      we_q    <= 1'b0;
      f3_q    <= 3'd0;
      wdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else if (accept) begin
      word_q  <= req_addr[ADDR_WIDTH+1:2];
      off_q   <= req_addr[1:0];
      we_q    <= req_we;
      f3_q    <= req_funct3;
      wdata_q <= req_wdata;
      err_q   <= acc_err;
    end
  end

  // Replicate store data across lanes so the byte enables pick the right copy.
  always_comb begin
    case (f3_q)
      F3_B:    ram_wdata = {4{wdata_q[7:0]}};
      F3_H:    ram_wdata = {2{wdata_q[15:0]}};
      default: ram_wdata = wdata_q;
    endcase
  end

  // A clear coinciding with the ACCESS edge must not let a write through.
  assign ram_en = (state_q == S_ACCESS) && !clear;
  assign ram_be = (we_q && !err_q) ? byte_enable(f3_q, off_q) : 4'b0000;

  byte_en_ram #(.ADDR_WIDTH(ADDR_WIDTH)) u_ram (
    .clock (clock),
    .en    (ram_en),
    .be    (ram_be),
    .addr  (word_q),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  // Align the addressed byte/half to bit 0, then sign- or zero-extend.
  always_comb begin
    shifted = ram_rdata >> {off_q, 3'b000};
    case (f3_q)
      F3_B:    load_data = {{24{shifted[7]}}, shifted[7:0]};
      F3_BU:   load_data = {24'd0, shifted[7:0]};
      F3_H:    load_data = {{16{shifted[15]}}, shifted[15:0]};
      F3_HU:   load_data = {16'd0, shifted[15:0]};
      default: load_data = shifted;
    endcase
  end

  // Response register: loaded on the first RESP cycle, held until taken.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= 32'd0;
    end else if (state_q == S_RESP && !rsp_valid_q) begin
      rsp_valid_q <= 1'b1;
      rsp_err_q   <= err_q;
      rsp_rdata_q <= (we_q || err_q) ? 32'd0 : load_data;
    end else if (rsp_valid_q && rsp_ready) begin
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= 32'd0;
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: three instances (WAIT_STATES 1, 0, 3) on one clock,
// directed transactions with hand-computed responses queued in a scoreboard
// and checked by a monitor whenever a response is taken.
module tb_dmem_responder;
  import riscv_mem_pkg::*;

  localparam logic [2:0] F3_BAD = 3'b011;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]  clear;
  logic [2:0]  req_valid;
  logic [2:0]  req_ready;
  logic [31:0] req_addr  [3];
  logic [2:0]  req_we;
  logic [2:0]  req_funct3 [3];
  logic [31:0] req_wdata [3];
  logic [2:0]  rsp_valid;
  logic [2:0]  rsp_ready;
  logic [31:0] rsp_rdata [3];
  logic [2:0]  rsp_err;
  logic [1:0]  state     [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    dmem_responder #(
      .ADDR_WIDTH  (10),
      .WAIT_STATES ((g == 0) ? 1 : ((g == 1) ? 0 : 3))
    ) dut (
      .clock      (clk),
      .clear      (clear[g]),
      .req_valid  (req_valid[g]),
      .req_ready  (req_ready[g]),
      .req_addr   (req_addr[g]),
      .req_we     (req_we[g]),
      .req_funct3 (req_funct3[g]),
      .req_wdata  (req_wdata[g]),
      .rsp_valid  (rsp_valid[g]),
      .rsp_ready  (rsp_ready[g]),
      .rsp_rdata  (rsp_rdata[g]),
      .rsp_err    (rsp_err[g]),
      .state      (state[g])
    );
  end

  // ---------------- scoreboard ----------------
  int          tests_run = 0;
  int          fails = 0;
  logic [34:0] exp_q [$];   // {dut[1:0], err, rdata}
  string       name_q [$];

  function automatic int ws_of(input int d);
    return (d == 0) ? 1 : ((d == 1) ? 0 : 3);
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    tests_run++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, required %h", nm, act, req);
    end
  endtask

  // Pops one expectation per response taken by the requester.
  task automatic monitor();
    logic [34:0] e;
    string       nm;
    forever begin
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
        if (rsp_valid[d] && rsp_ready[d]) begin
          tests_run++;
          if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL rsp_unexpected dut%0d: got err=%0b rdata=%h, required no response",
                     d, rsp_err[d], rsp_rdata[d]);
          end else begin
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            if (e[34:33] != 2'(d) || e[32] !== rsp_err[d] || e[31:0] !== rsp_rdata[d]) begin
              fails++;
              $display("FAIL %s: got dut%0d err=%0b rdata=%h, required dut%0d err=%0b rdata=%h",
                       nm, d, rsp_err[d], rsp_rdata[d], e[34:33], e[32], e[31:0]);
            end
          end
        end
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  // Present a request and return #1 after the edge that accepts it.
  task automatic issue(input int d, input logic we, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wdata);
    int n;
    req_we[d]     = we;
    req_funct3[d] = f3;
    req_addr[d]   = addr;
    req_wdata[d]  = wdata;
    req_valid[d]  = 1'b1;
    n = 0;
    while (!req_ready[d] && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!req_ready[d]) begin
      tests_run++;
      fails++;
      $display("FAIL accept_timeout dut%0d: got req_ready=0, required 1", d);
    end
    @(posedge clk); #1;
    req_valid[d] = 1'b0;
  endtask

  // Full transaction: queue the expected response, issue, check latency, wait for retire.
  task automatic txn(input int d, input string nm, input logic we, input logic [2:0] f3,
                     input logic [31:0] addr, input logic [31:0] wdata,
                     input logic exp_err, input logic [31:0] exp_rdata);
    int n;
    exp_q.push_back({2'(d), exp_err, exp_rdata});
    name_q.push_back(nm);
    issue(d, we, f3, addr, wdata);
    n = 0;
    while (!rsp_valid[d] && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check({"lat_", nm}, 32'(n), 32'(ws_of(d) + 2));
    n = 0;
    while (rsp_valid[d] && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check({"retire_", nm}, {31'd0, rsp_valid[d]}, 32'd0);
  endtask

  // Clear while a store is in flight; the store must be dropped.
  task automatic clear_store(input int d, input logic [31:0] addr);
    issue(d, 1'b1, F3_W, addr, 32'h12345678);
    clear[d] = 1'b1;
    #1;
    check($sformatf("clr_rsp_valid_dut%0d", d), {31'd0, rsp_valid[d]}, 32'd0);
    check($sformatf("clr_req_ready_dut%0d", d), {31'd0, req_ready[d]}, 32'd1);
    check($sformatf("clr_state_dut%0d", d), {30'd0, state[d]}, 32'd0);
    @(posedge clk); #1;
    clear[d] = 1'b0;
    @(posedge clk); #1;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int n;
    clear     = 3'b111;
    req_valid = 3'b000;
    req_we    = 3'b000;
    rsp_ready = 3'b111;
    for (int d = 0; d < 3; d++) begin
      req_addr[d]   = 32'd0;
      req_funct3[d] = 3'd0;
      req_wdata[d]  = 32'd0;
    end
    #1;
    for (int d = 0; d < 3; d++) begin
      check($sformatf("rst_req_ready_dut%0d", d), {31'd0, req_ready[d]}, 32'd1);
      check($sformatf("rst_rsp_valid_dut%0d", d), {31'd0, rsp_valid[d]}, 32'd0);
      check($sformatf("rst_rsp_rdata_dut%0d", d), rsp_rdata[d], 32'd0);
      check($sformatf("rst_rsp_err_dut%0d", d), {31'd0, rsp_err[d]}, 32'd0);
      check($sformatf("rst_state_dut%0d", d), {30'd0, state[d]}, 32'd0);
    end
    #11;
    clear = 3'b000;
    @(posedge clk); #1;
    fork
      monitor();
    join_none

    // word store / load
    txn(0, "sw_10",  1'b1, F3_W, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0);
    txn(0, "lw_10",  1'b0, F3_W, 32'h10, 32'h0,        1'b0, 32'hDEADBEEF);

    // byte store into a zeroed word, signed/unsigned byte loads, word readback
    txn(0, "sw_20",  1'b1, F3_W,  32'h20, 32'h0,        1'b0, 32'h0);
    txn(0, "sb_21",  1'b1, F3_B,  32'h21, 32'hFFFFFF80, 1'b0, 32'h0);
    txn(0, "lb_21",  1'b0, F3_B,  32'h21, 32'h0,        1'b0, 32'hFFFFFF80);
    txn(0, "lbu_21", 1'b0, F3_BU, 32'h21, 32'h0,        1'b0, 32'h00000080);
    txn(0, "lw_20",  1'b0, F3_W,  32'h20, 32'h0,        1'b0, 32'h00008000);

    // halfword store/loads, misaligned accesses
    txn(0, "sw_30",  1'b1, F3_W,  32'h30, 32'h0,        1'b0, 32'h0);
    txn(0, "sh_32",  1'b1, F3_H,  32'h32, 32'h1234BEEF, 1'b0, 32'h0);
    txn(0, "lh_32",  1'b0, F3_H,  32'h32, 32'h0,        1'b0, 32'hFFFFBEEF);
    txn(0, "lhu_32", 1'b0, F3_HU, 32'h32, 32'h0,        1'b0, 32'h0000BEEF);
    txn(0, "lw_30",  1'b0, F3_W,  32'h30, 32'h0,        1'b0, 32'hBEEF0000);
    txn(0, "lh_31",  1'b0, F3_H,  32'h31, 32'h0,        1'b1, 32'h0);
    txn(0, "sw_12",  1'b1, F3_W,  32'h12, 32'h55555555, 1'b1, 32'h0);
    txn(0, "lw_10b", 1'b0, F3_W,  32'h10, 32'h0,        1'b0, 32'hDEADBEEF);

    // range and illegal width codes; top in-range word
    txn(0, "lw_1000", 1'b0, F3_W,   32'h1000, 32'h0,        1'b1, 32'h0);
    txn(0, "ld_bad",  1'b0, F3_BAD, 32'h10,   32'h0,        1'b1, 32'h0);
    txn(0, "sw_f100", 1'b1, F3_BU,  32'h10,   32'h01010101, 1'b1, 32'h0);
    txn(0, "sw_f101", 1'b1, F3_HU,  32'h10,   32'h02020202, 1'b1, 32'h0);
    txn(0, "lw_10c",  1'b0, F3_W,   32'h10,   32'h0,        1'b0, 32'hDEADBEEF);
    txn(0, "sw_ffc",  1'b1, F3_W,   32'hFFC,  32'hA5A5C3C3, 1'b0, 32'h0);
    txn(0, "lb_fff",  1'b0, F3_B,   32'hFFF,  32'h0,        1'b0, 32'hFFFFFFA5);

    // response backpressure with a second request already waiting
    rsp_ready[0] = 1'b0;
    exp_q.push_back({2'd0, 1'b0, 32'hDEADBEEF});
    name_q.push_back("hold_lw_10");
    issue(0, 1'b0, F3_W, 32'h10, 32'h0);
    n = 0;
    while (!rsp_valid[0] && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    exp_q.push_back({2'd0, 1'b0, 32'h00008000});
    name_q.push_back("after_hold_lw_20");
    req_we[0] = 1'b0; req_funct3[0] = F3_W; req_addr[0] = 32'h20; req_valid[0] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("hold_rsp_valid", {31'd0, rsp_valid[0]}, 32'd1);
      check("hold_rsp_rdata", rsp_rdata[0], 32'hDEADBEEF);
      check("hold_req_ready", {31'd0, req_ready[0]}, 32'd0);
      @(posedge clk); #1;
    end
    rsp_ready[0] = 1'b1;
    @(posedge clk); #1;
    check("release_req_ready", {31'd0, req_ready[0]}, 32'd1);
    check("release_rsp_valid", {31'd0, rsp_valid[0]}, 32'd0);
    @(posedge clk); #1;
    check("same_cycle_accept_state", {30'd0, state[0]}, 32'(ws_of(0) > 0 ? 1 : 2));
    req_valid[0] = 1'b0;
    n = 0;
    while (!(rsp_valid[0] == 1'b0 && state[0] == 2'd0) && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("after_hold_idle", {30'd0, state[0]}, 32'd0);

    // clear during an in-flight store, all three wait-state settings
    for (int d = 0; d < 3; d++) begin
      txn(d, $sformatf("pre_sw_40_dut%0d", d), 1'b1, F3_W, 32'h40, 32'h11112222, 1'b0, 32'h0);
      clear_store(d, 32'h40);
      txn(d, $sformatf("post_lw_40_dut%0d", d), 1'b0, F3_W, 32'h40, 32'h0, 1'b0, 32'h11112222);
      txn(d, $sformatf("sh_46_dut%0d", d), 1'b1, F3_H, 32'h46, 32'h00008001, 1'b0, 32'h0);
      txn(d, $sformatf("lh_46_dut%0d", d), 1'b0, F3_H, 32'h46, 32'h0, 1'b0, 32'hFFFF8001);
    end

    repeat (5) @(posedge clk);
    #1;
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
